// File: rtl/video_noise_gen.sv
// Grey-noise video source with NTSC/PAL, single/double-rate raster timing.
// A Fibonacci LFSR supplies visible pixels and is reseeded every frame, so all frames are identical.
module video_noise_gen #(
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          H_TOTAL   = 400,
    parameter int          H_ACTIVE  = 320
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pal,
    input  logic       scandouble,
    output logic       ce_pix,
    output logic       HBlank,
    output logic       HSync,
    output logic       VBlank,
    output logic       VSync,
    output logic [7:0] video
);

    localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
    localparam logic [9:0] HA     = 10'(H_ACTIVE);
    localparam logic [9:0] HS_LO  = 10'(H_ACTIVE + 16);
    localparam logic [9:0] HS_HI  = 10'(H_ACTIVE + 47);

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    logic [1:0]  r_cnt;
    logic        r_ce;
    logic        r_pal;
    logic        r_sd;
    logic [8:0]  r_hc;
    logic [9:0]  r_vc;
    logic [15:0] r_lfsr;
    logic        r_hblank;
    logic        r_hsync;
    logic        r_vblank;
    logic        r_vsync;
    logic [7:0]  r_video;

    logic [1:0]  w_cnt_next;
    logic        w_sd_next;
    logic        w_ce_next;
    logic [9:0]  w_vtotal;
    logic [9:0]  w_vc_eff;
    logic [9:0]  w_vact;
    logic [9:0]  w_vs_lo;
    logic [9:0]  w_vs_hi;
    logic        w_hb;
    logic        w_hs;
    logic        w_vb;
    logic        w_vs;
    logic        w_h_last;
    logic        w_v_last;
    logic        w_frame_wrap;
    logic [8:0]  w_hc_next;
    logic [9:0]  w_vc_next;
    logic [15:0] w_lfsr_next;

    // Vertical table lookup and raster decode from the current (pre-increment) counters
    always_comb begin
        case ({r_pal, r_sd})
            2'b00:   w_vtotal = 10'd262;
            2'b10:   w_vtotal = 10'd312;
            2'b01:   w_vtotal = 10'd524;
            2'b11:   w_vtotal = 10'd624;
            default: w_vtotal = 10'd262;
        endcase
        // Double-rate lines are folded onto the single-rate table by halving vc.
        if (r_sd) begin
            w_vc_eff = {1'b0, r_vc[9:1]};
        end else begin
            w_vc_eff = r_vc;
        end
        if (r_pal) begin
            w_vact  = 10'd288;
            w_vs_lo = 10'd294;
            w_vs_hi = 10'd296;
        end else begin
            w_vact  = 10'd240;
            w_vs_lo = 10'd244;
            w_vs_hi = 10'd246;
        end
        w_hb         = ({1'b0, r_hc} >= HA);
        w_hs         = ({1'b0, r_hc} >= HS_LO) && ({1'b0, r_hc} <= HS_HI);
        w_vb         = (w_vc_eff >= w_vact);
        w_vs         = (w_vc_eff >= w_vs_lo) && (w_vc_eff <= w_vs_hi);
        w_h_last     = (r_hc == H_LAST);
        w_v_last     = (r_vc == (w_vtotal - 10'd1));
        w_frame_wrap = r_ce && w_h_last && w_v_last;
    end

    // Next-state values for divider, counters and noise generator
    always_comb begin
        w_cnt_next = r_cnt + 2'd1;
        if (w_frame_wrap) begin
            w_sd_next = scandouble;
        end else begin
            w_sd_next = r_sd;
        end
        if (w_sd_next) begin
            w_ce_next = w_cnt_next[0];
        end else begin
            w_ce_next = (w_cnt_next == 2'd3);
        end
        w_hc_next = r_hc;
        w_vc_next = r_vc;
        if (r_ce) begin
            if (w_h_last) begin
                w_hc_next = 9'd0;
                if (w_v_last) begin
                    w_vc_next = 10'd0;
                end else begin
                    w_vc_next = r_vc + 10'd1;
                end
            end else begin
                w_hc_next = r_hc + 9'd1;
            end
        end else begin
            w_hc_next = r_hc;
        end
        w_lfsr_next = r_lfsr;
        if (w_frame_wrap) begin
            w_lfsr_next = LFSR_SEED;
        end else if (r_ce) begin
            if (r_lfsr == 16'h0000) begin
                w_lfsr_next = LFSR_SEED;
            end else if (!w_hb && !w_vb) begin
                w_lfsr_next = lfsr_step(r_lfsr);
            end else begin
                w_lfsr_next = r_lfsr;
            end
        end else begin
            w_lfsr_next = r_lfsr;
        end
    end

    // Clock divider, registered pixel enable and mode latch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= 2'd0;
            r_ce  <= 1'b0;
            r_pal <= 1'b0;
            r_sd  <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            r_ce  <= w_ce_next;
            r_sd  <= w_sd_next;
            if (w_frame_wrap) begin
                r_pal <= pal;
            end else begin
                r_pal <= r_pal;
            end
        end
    end

    // Raster counters, noise state and per-pixel output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hc     <= 9'd0;
            r_vc     <= 10'd0;
            r_lfsr   <= LFSR_SEED;
            r_hblank <= 1'b0;
            r_hsync  <= 1'b0;
            r_vblank <= 1'b0;
            r_vsync  <= 1'b0;
            r_video  <= 8'h00;
        end else begin
            r_hc   <= w_hc_next;
            r_vc   <= w_vc_next;
            r_lfsr <= w_lfsr_next;
            if (r_ce) begin
                r_hblank <= w_hb;
                r_hsync  <= w_hs;
                r_vblank <= w_vb;
                r_vsync  <= w_vs;
                r_video  <= (!w_hb && !w_vb) ? r_lfsr[7:0] : 8'h00;
            end
        end
    end

    assign ce_pix = r_ce;
    assign HBlank = r_hblank;
    assign HSync  = r_hsync;
    assign VBlank = r_vblank;
    assign VSync  = r_vsync;
    assign video  = r_video;

endmodule
